// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch front end.
// Issues sequential fetches to instruction memory, buffers returned instructions
// with their PCs in a small queue, and hands them to the core over valid/ready.
// Redirects flush the queue and drain stale in-flight responses.
// Optional macro IF_FETCH_PERF_EN adds perf_fetched / perf_dropped counters.
module if_fetch_stage #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       Q_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_dropped
`endif
);

    localparam int unsigned PW  = $clog2(Q_DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned CW1 = CW + 1;
    localparam logic [CW:0]        DEPTH_C = CW1'(Q_DEPTH);
    localparam logic [ADDR_W-1:0]  STEP_C  = ADDR_W'(PC_STEP);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop_cnt;

    logic [ADDR_W-1:0] q_pc   [Q_DEPTH];
    logic [DATA_W-1:0] q_data [Q_DEPTH];
    logic [PW-1:0]     q_head;
    logic [PW-1:0]     q_tail;
    logic [CW-1:0]     q_count;

    logic [ADDR_W-1:0] p_pc   [Q_DEPTH];
    logic [PW-1:0]     p_head;
    logic [PW-1:0]     p_tail;

    logic [CW:0]       credit_used;
    logic              req_fire;
    logic              rsp_hit;
    logic              drain_hit;
    logic              rsp_take;
    logic              pop;
    logic [CW-1:0]     redirect_drop;

    // Credit check counts queued entries plus in-flight requests so the queue never overflows.
    assign credit_used    = {1'b0, q_count} + {1'b0, outstanding};
    assign imem_req_valid = !reset && (state == RUN) && (credit_used < DEPTH_C) && !redirect_valid;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response in RUN with nothing outstanding is a protocol error and is ignored.
    assign rsp_hit   = (state == RUN) && imem_rsp_valid && (outstanding != '0);
    assign drain_hit = (state == DRAIN) && imem_rsp_valid && (drop_cnt != '0);
    assign rsp_take  = rsp_hit && !redirect_valid;

    // Redirect cancels any pop in the same cycle; the core is abandoning this stream.
    assign if_valid = (q_count != '0);
    assign pop      = if_valid && if_ready && !redirect_valid;
    assign if_instr = q_data[q_head];
    assign if_pc    = q_pc[q_head];

    // Responses still owed by memory once a redirect lands; they must all be discarded.
    assign redirect_drop = (state == RUN)
                         ? (outstanding + CW'(req_fire) - CW'(rsp_hit))
                         : (drop_cnt - CW'(drain_hit));

    // Fetch PC, outstanding count, drop count and RUN/DRAIN state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_pc;
            outstanding <= '0;
            drop_cnt    <= redirect_drop;
            state       <= (redirect_drop != '0) ? DRAIN : RUN;
        end else if (state == RUN) begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + STEP_C;
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
        end else begin
            if (drain_hit) begin
                drop_cnt <= drop_cnt - CW'(1);
                if (drop_cnt == CW'(1)) begin
                    state <= RUN;
                end
            end
        end
    end

    // Pending-PC FIFO: remembers the address of each accepted request until its response returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_head <= '0;
            p_tail <= '0;
            for (int i = 0; i < int'(Q_DEPTH); i++) begin
                p_pc[i] <= '0;
            end
        end else if (redirect_valid) begin
            p_head <= '0;
            p_tail <= '0;
        end else begin
            if (req_fire) begin
                p_pc[p_tail] <= fetch_pc;
                p_tail       <= p_tail + PW'(1);
            end
            if (rsp_take) begin
                p_head <= p_head + PW'(1);
            end
        end
    end

    // Instruction queue: responses enter at the tail paired with their PC, the core pops the head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_head  <= '0;
            q_tail  <= '0;
            q_count <= '0;
            for (int i = 0; i < int'(Q_DEPTH); i++) begin
                q_pc[i]   <= '0;
                q_data[i] <= '0;
            end
        end else if (redirect_valid) begin
            q_head  <= '0;
            q_tail  <= '0;
            q_count <= '0;
        end else begin
            if (rsp_take) begin
                q_pc[q_tail]   <= p_pc[p_head];
                q_data[q_tail] <= imem_rsp_data;
                q_tail         <= q_tail + PW'(1);
            end
            if (pop) begin
                q_head <= q_head + PW'(1);
            end
            q_count <= q_count + CW'(rsp_take) - CW'(pop);
        end
    end

`ifdef IF_FETCH_PERF_EN
    // Performance counters: instructions taken by the core, and responses/entries thrown away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            perf_dropped <= perf_dropped
                          + (redirect_valid ? 32'(q_count) : 32'd0)
                          + 32'(drain_hit);
        end
    end
`endif

endmodule
